trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl_pkg.sv | 44 ++++
 rtl/trap_csr.sv | 111 +++++++++++
 rtl/trap_ctrl.sv | 119 +++++++++++
 tb/tb_trap_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: shared types and constants for the machine-mode trap controller.
//   commit_entry     - retiring instruction (pc + execution result)
//   CSR_*            - CSR addresses served by trap_csr
//   MSTATUS_*        - mstatus field bit positions
//   EX_*             - exception cause codes (4-bit, zero-extended into mcause)
//   trap_state_e     - trap_ctrl FSM states
package trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [3:0] EX_INSTR_MISALIGN = 4'd0;
  localparam logic [3:0] EX_ILLEGAL_INSTR  = 4'd2;
  localparam logic [3:0] EX_BREAKPOINT     = 4'd3;
  localparam logic [3:0] EX_M_ECALL        = 4'd11;

  typedef struct packed {
    logic        ex_valid;
    logic [3:0]  ex;
    logic [31:0] ex_tval;
    logic        ret_valid;
    logic        br_valid;
  } exec_result;

  typedef struct packed {
    logic [31:0] pc;
    exec_result  exec;
  } commit_entry;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_TRAP     = 2'd1,
    S_REDIRECT = 2'd2
  } trap_state_e;

endpackage

// File: rtl/trap_csr.sv
// trap_csr: machine-mode trap CSR file (mstatus, mtvec, mepc, mcause, mtval).
// Ports:
//   clk, rst              - clock, asynchronous active-low reset
//   csr_addr/we/wdata     - CSR instruction write path (any time)
//   csr_rdata             - combinational read of csr_addr (0 for unknown addresses)
//   trap_exc, trap_ret    - one-cycle trap entry / return update strobes
//   trap_pc, trap_cause   - exception pc (word aligned) and cause code
//   trap_tval             - exception value (only with TRAP_MTVAL_EN)
//   mtvec_base, mepc_base - word-aligned vector / return addresses for redirect
// Macro TRAP_MTVAL_EN: implements mtval; otherwise mtval reads 0 and has no storage.
module trap_csr
  import trap_ctrl_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h8000_0000,
  parameter logic [1:0]  MSTATUS_MPP = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] csr_addr,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  input  logic        trap_exc,
  input  logic        trap_ret,
  input  logic [31:2] trap_pc,
  input  logic [3:0]  trap_cause,
`ifdef TRAP_MTVAL_EN
  input  logic [31:0] trap_tval,
`endif
  output logic [31:2] mtvec_base,
  output logic [31:2] mepc_base
);

  logic        mie_q;
  logic        mpie_q;
  logic [31:2] mtvec_q;
  logic [31:2] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_rd;

`ifdef TRAP_MTVAL_EN
  logic [31:0] mtval_q;
  assign mtval_rd = mtval_q;
`else
  assign mtval_rd = '0;
`endif

  // Trap updates are written after the CSR-instruction write so they win on collision;
  // both sample the pre-edge mie_q/mpie_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mtvec_q  <= MTVEC_RESET[31:2];
      mepc_q   <= '0;
      mcause_q <= '0;
`ifdef TRAP_MTVAL_EN
      mtval_q  <= '0;
`endif
    end else begin
      if (csr_we) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            mie_q  <= csr_wdata[MSTATUS_MIE];
            mpie_q <= csr_wdata[MSTATUS_MPIE];
          end
          CSR_MTVEC:  mtvec_q  <= csr_wdata[31:2];
          CSR_MEPC:   mepc_q   <= csr_wdata[31:2];
          CSR_MCAUSE: mcause_q <= csr_wdata;
`ifdef TRAP_MTVAL_EN
          CSR_MTVAL:  mtval_q  <= csr_wdata;
`endif
          default: ;
        endcase
      end
      if (trap_exc) begin
        mepc_q   <= trap_pc;
        mcause_q <= {28'd0, trap_cause};
`ifdef TRAP_MTVAL_EN
        mtval_q  <= trap_tval;
`endif
        mpie_q   <= mie_q;
        mie_q    <= 1'b0;
      end
      if (trap_ret) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[MSTATUS_MIE]                   = mie_q;
        csr_rdata[MSTATUS_MPIE]                  = mpie_q;
        csr_rdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = MSTATUS_MPP;
      end
      CSR_MTVEC:  csr_rdata = {mtvec_q, 2'b00};
      CSR_MEPC:   csr_rdata = {mepc_q, 2'b00};
      CSR_MCAUSE: csr_rdata = mcause_q;
      CSR_MTVAL:  csr_rdata = mtval_rd;
      default:    csr_rdata = '0;
    endcase
  end

  assign mtvec_base = mtvec_q;
  assign mepc_base  = mepc_q;

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer. Accepts a retiring instruction, and on an
// exception or mret walks IDLE -> TRAP (flush, CSR update) -> REDIRECT (fetch redirect).
// Ports:
//   clk, rst                        - clock, asynchronous active-low reset
//   commit_valid/ready/data         - decoupled commit input (ready only in IDLE)
//   flush                           - pipeline flush, high for the TRAP cycle
//   redirect_valid/redirect_target  - one-cycle fetch redirect in REDIRECT
//   csr_addr/we/wdata/rdata         - CSR access port into trap_csr
// Macro TRAP_MTVAL_EN: enables the mtval CSR (ex_tval is otherwise unused).
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h8000_0000,
  parameter logic [1:0]  MSTATUS_MPP = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  output logic        commit_ready,
  input  commit_entry commit_data,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_target,
  input  logic [11:0] csr_addr,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata
);

  trap_state_e state_q, state_d;
  logic        trap_exc, trap_ret;
  logic [31:2] mtvec_base, mepc_base;

  logic        is_ret_p1;
  logic [31:2] pc_p1;
  logic [3:0]  ex_p1;
`ifdef TRAP_MTVAL_EN
  logic [31:0] tval_p1;
`endif

  logic unused_commit_bits;
`ifdef TRAP_MTVAL_EN
  assign unused_commit_bits = ^{commit_data.pc[1:0], commit_data.exec.br_valid};
`else
  assign unused_commit_bits = ^{commit_data.pc[1:0], commit_data.exec.br_valid,
                                commit_data.exec.ex_tval};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Commit capture -> TRAP/REDIRECT stages. Loaded on every valid beat in IDLE; only
  // consumed when that beat starts a trap. ex_valid has priority over ret_valid.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && commit_valid) begin
      is_ret_p1 <= ~commit_data.exec.ex_valid;
      pc_p1     <= commit_data.pc[31:2];
      ex_p1     <= commit_data.exec.ex;
`ifdef TRAP_MTVAL_EN
      tval_p1   <= commit_data.exec.ex_tval;
`endif
    end
  end

  always_comb begin
    state_d         = state_q;
    commit_ready    = 1'b0;
    flush           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    trap_exc        = 1'b0;
    trap_ret        = 1'b0;
    case (state_q)
      S_IDLE: begin
        // rst gating keeps ready low while reset is held (state is already IDLE then).
        commit_ready = rst;
        if (commit_valid && (commit_data.exec.ex_valid || commit_data.exec.ret_valid))
          state_d = S_TRAP;
      end
      S_TRAP: begin
        flush    = 1'b1;
        trap_exc = ~is_ret_p1;
        trap_ret = is_ret_p1;
        state_d  = S_REDIRECT;
      end
      S_REDIRECT: begin
        // CSRs here already hold the TRAP-cycle updates and any TRAP-cycle csr_we.
        redirect_valid  = 1'b1;
        redirect_target = is_ret_p1 ? {mepc_base, 2'b00} : {mtvec_base, 2'b00};
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  trap_csr #(
    .MTVEC_RESET (MTVEC_RESET),
    .MSTATUS_MPP (MSTATUS_MPP)
  ) u_csr (
    .clk        (clk),
    .rst        (rst),
    .csr_addr   (csr_addr),
    .csr_we     (csr_we),
    .csr_wdata  (csr_wdata),
    .csr_rdata  (csr_rdata),
    .trap_exc   (trap_exc),
    .trap_ret   (trap_ret),
    .trap_pc    (pc_p1),
    .trap_cause (ex_p1),
`ifdef TRAP_MTVAL_EN
    .trap_tval  (tval_p1),
`endif
    .mtvec_base (mtvec_base),
    .mepc_base  (mepc_base)
  );

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed scenarios plus randomized commits/CSR writes for trap_ctrl,
// checked against a transaction-level model of the architectural CSR state.
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid;
  logic        commit_ready;
  commit_entry commit_data;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;

  int total = 0;
  int bad   = 0;

  // Model of architectural CSR state
  logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval;
  logic        m_mie, m_mpie;

  always #5 clk = ~clk;

  trap_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .commit_valid    (commit_valid),
    .commit_ready    (commit_ready),
    .commit_data     (commit_data),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .csr_addr        (csr_addr),
    .csr_we          (csr_we),
    .csr_wdata       (csr_wdata),
    .csr_rdata       (csr_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    m_mtvec  = 32'h8000_0000;
    m_mepc   = '0;
    m_mcause = '0;
    m_mtval  = '0;
    m_mie    = 1'b0;
    m_mpie   = 1'b0;
  endfunction

  function automatic void model_write(input logic [11:0] a, input logic [31:0] d);
    case (a)
      12'h300: begin m_mie = d[3]; m_mpie = d[7]; end
      12'h305: m_mtvec  = d & 32'hFFFF_FFFC;
      12'h341: m_mepc   = d & 32'hFFFF_FFFC;
      12'h342: m_mcause = d;
`ifdef TRAP_MTVAL_EN
      12'h343: m_mtval  = d;
`endif
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h0000_1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      default: return 32'h0;
    endcase
  endfunction

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_addr  = a;
    csr_wdata = d;
    csr_we    = 1'b1;
    step();
    csr_we = 1'b0;
    model_write(a, d);
  endtask

  task automatic check_csr(input string tag, input logic [11:0] a);
    csr_addr = a;
    #1;
    chk(tag, csr_rdata, model_read(a));
  endtask

  task automatic check_all_csrs(input string tag);
    logic [11:0] other;
    check_csr({tag, ".mstatus"}, 12'h300);
    check_csr({tag, ".mtvec"},   12'h305);
    check_csr({tag, ".mepc"},    12'h341);
    check_csr({tag, ".mcause"},  12'h342);
    check_csr({tag, ".mtval"},   12'h343);
    do other = 12'($urandom);
    while (other == 12'h300 || other == 12'h305 || other == 12'h341 ||
           other == 12'h342 || other == 12'h343);
    check_csr({tag, ".other"}, other);
  endtask

  // One commit beat in IDLE; follows the trap sequence (if any) back to IDLE.
  // tw_* optionally issues a CSR write during the TRAP cycle.
  task automatic do_commit(input string tag, input logic [31:0] pc, input logic exv,
                           input logic [3:0] ex, input logic [31:0] tval, input logic retv,
                           input logic tw_en, input logic [11:0] tw_addr,
                           input logic [31:0] tw_data);
    logic        old_mie, old_mpie;
    logic [31:0] exp_tgt;
    commit_data.pc             = pc;
    commit_data.exec.ex_valid  = exv;
    commit_data.exec.ex        = ex;
    commit_data.exec.ex_tval   = tval;
    commit_data.exec.ret_valid = retv;
    commit_data.exec.br_valid  = 1'($urandom);
    chk({tag, ".ready_idle"}, commit_ready, 1);
    commit_valid = 1'b1;
    step();
    commit_valid = 1'b0;
    if (!(exv || retv)) begin
      chk({tag, ".noflush"}, flush, 0);
      chk({tag, ".noredir"}, redirect_valid, 0);
      chk({tag, ".ready_nop"}, commit_ready, 1);
      return;
    end
    chk({tag, ".flush"}, flush, 1);
    chk({tag, ".redir_trap"}, redirect_valid, 0);
    chk({tag, ".ready_trap"}, commit_ready, 0);
    if (tw_en) begin
      csr_addr  = tw_addr;
      csr_wdata = tw_data;
      csr_we    = 1'b1;
    end
    old_mie  = m_mie;
    old_mpie = m_mpie;
    step();
    csr_we = 1'b0;
    if (tw_en) model_write(tw_addr, tw_data);
    if (exv) begin
      m_mepc   = pc & 32'hFFFF_FFFC;
      m_mcause = 32'(ex);
`ifdef TRAP_MTVAL_EN
      m_mtval  = tval;
`endif
      m_mpie   = old_mie;
      m_mie    = 1'b0;
      exp_tgt  = m_mtvec;
    end else begin
      m_mie   = old_mpie;
      m_mpie  = 1'b1;
      exp_tgt = m_mepc;
    end
    chk({tag, ".flush_off"}, flush, 0);
    chk({tag, ".redir"}, redirect_valid, 1);
    chk({tag, ".target"}, redirect_target, exp_tgt);
    chk({tag, ".ready_redir"}, commit_ready, 0);
    step();
    chk({tag, ".redir_off"}, redirect_valid, 0);
    chk({tag, ".target_off"}, redirect_target, 0);
    chk({tag, ".ready_back"}, commit_ready, 1);
  endtask

  initial begin
    rst          = 1'b0;
    commit_valid = 1'b0;
    commit_data  = '0;
    csr_addr     = '0;
    csr_we       = 1'b0;
    csr_wdata    = '0;
    model_reset();
    step();
    step();
    chk("rst.ready", commit_ready, 0);
    chk("rst.flush", flush, 0);
    chk("rst.redir", redirect_valid, 0);
    chk("rst.target", redirect_target, 0);
    rst = 1'b1;
    step();
    chk("rst.ready_release", commit_ready, 1);
    check_all_csrs("rst");

    // Exception entry with MIE set
    csr_write(12'h300, 32'h0000_0008);
    do_commit("exc", 32'h8000_0104, 1'b1, EX_ILLEGAL_INSTR, 32'h0000_1234, 1'b0,
              1'b0, 12'h0, 32'h0);
    chk("exc.mcause_lit", model_read(12'h342), 32'd2);
    check_all_csrs("exc");

    // Return
    csr_write(12'h341, 32'h8000_0200);
    csr_write(12'h300, 32'h0000_0080);
    do_commit("ret", 32'h0000_0040, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 12'h0, 32'h0);
    check_all_csrs("ret");

    // Exception wins over return
    do_commit("prio", 32'h0000_1002, 1'b1, EX_M_ECALL, 32'hABCD_0000, 1'b1,
              1'b0, 12'h0, 32'h0);
    check_all_csrs("prio");

    // Collisions in the TRAP cycle
    do_commit("coll_mcause", 32'h0000_2000, 1'b1, EX_BREAKPOINT, 32'h0, 1'b0,
              1'b1, 12'h342, 32'h0000_0055);
    check_all_csrs("coll_mcause");
    do_commit("coll_mtvec", 32'h0000_3000, 1'b1, EX_BREAKPOINT, 32'h0, 1'b0,
              1'b1, 12'h305, 32'h9000_0003);
    check_all_csrs("coll_mtvec");

    // mtval behaviour (disabled build: always reads 0)
    do_commit("tval", 32'h0000_4000, 1'b1, EX_ILLEGAL_INSTR, 32'h0000_DEAD, 1'b0,
              1'b0, 12'h0, 32'h0);
    check_csr("tval.after_exc", 12'h343);
    csr_write(12'h343, 32'h0000_0001);
    check_csr("tval.after_wr", 12'h343);

    // Reset during REDIRECT
    commit_data.pc             = 32'h0000_5000;
    commit_data.exec.ex_valid  = 1'b1;
    commit_data.exec.ex        = EX_M_ECALL;
    commit_data.exec.ret_valid = 1'b0;
    commit_valid = 1'b1;
    step();
    commit_valid = 1'b0;
    step();
    chk("rstr.redir_before", redirect_valid, 1);
    rst = 1'b0;
    #1;
    chk("rstr.redir", redirect_valid, 0);
    chk("rstr.target", redirect_target, 0);
    chk("rstr.flush", flush, 0);
    chk("rstr.ready", commit_ready, 0);
    step();
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rstr.no_redir", redirect_valid, 0);
      chk("rstr.no_flush", flush, 0);
    end
    chk("rstr.ready", commit_ready, 1);
    check_all_csrs("rstr");

    // Reset during TRAP
    commit_data.exec.ex_valid = 1'b1;
    commit_valid = 1'b1;
    step();
    commit_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rstt.flush", flush, 0);
    step();
    rst = 1'b1;
    model_reset();
    step();
    chk("rstt.no_redir", redirect_valid, 0);
    chk("rstt.ready", commit_ready, 1);
    check_all_csrs("rstt");

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [11:0] a;
      case ($urandom_range(0, 5))
        0: a = 12'h300;
        1: a = 12'h305;
        2: a = 12'h341;
        3: a = 12'h342;
        4: a = 12'h343;
        default: a = 12'($urandom);
      endcase
      if ($urandom_range(0, 2) == 0) begin
        csr_write(a, $urandom);
      end else begin
        do_commit("rnd", $urandom, 1'($urandom), 4'($urandom), $urandom, 1'($urandom),
                  ($urandom_range(0, 3) == 0), a, $urandom);
      end
      if (i % 10 == 0) check_all_csrs("rnd");
    end
    check_all_csrs("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
